fmlarb: RTL and testbench

- Shares the single FML memory port between nmasters requesters, for example the CPU bridge, video framebuffer, texture mapper and DMA.
- Grants are round-robin. A grant is held from address phase through the full data burst, so write data and sel are routed from the owning master only.
- Sits between the FML masters and the memory controller. Probes such as the FML meter attach to its slave-side signals.

---
 rtl/fmlarb_defs.sv | 27 ++
 rtl/fmlarb_rr.sv | 30 +++
 rtl/fmlarb.sv | 117 +++++++++++
 tb/tb_fmlarb.sv | 272 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/fmlarb_defs.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | fmlarb_defs : shared state encodings and elaboration helpers for fmlarb  |
// | Rev 1.0                                                                  |
// +--------------------------------------------------------------------------+
package fmlarb_defs;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ADDR = 2'd1,
        DATA = 2'd2
    } state_e;

    localparam int c_BURST_LENGTH = 4;

    // Ceiling log2, usable in parameter expressions.
    function automatic int clog2(input int value);
        int r;
        r = 0;
        while ((1 << r) < value) begin
            r = r + 1;
        end
        return r;
    endfunction

endpackage
`default_nettype wire

// File: rtl/fmlarb_rr.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | fmlarb_rr : combinational rotating-priority picker, search starts after  |
// | the previous owner and wraps. Rev 1.0                                    |
// +--------------------------------------------------------------------------+
module fmlarb_rr
    import fmlarb_defs::*;
#(
    parameter int nmasters = 4,
    localparam int c_OW    = clog2(nmasters)
) (
    input  logic [nmasters-1:0] req_i,
    input  logic [c_OW-1:0]     last_i,
    output logic [c_OW-1:0]     winner_o,
    output logic                any_o
);

    // Scan farthest-first so the nearest requester after last_i wins.
    always_comb begin
        winner_o = last_i;
        any_o    = |req_i;
        for (int k = nmasters; k >= 1; k--) begin
            if (req_i[(int'(last_i) + k) % nmasters]) begin
                winner_o = c_OW'((int'(last_i) + k) % nmasters);
            end
        end
    end

endmodule
`default_nettype wire

// File: rtl/fmlarb.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | fmlarb : round-robin arbiter sharing one FML port among nmasters, grant  |
// | held from address phase through the full data burst. Rev 1.0            |
// +--------------------------------------------------------------------------+
module fmlarb
    import fmlarb_defs::*;
#(
    parameter int fml_depth    = 26,
    parameter int nmasters     = 4,
    parameter int burst_length = c_BURST_LENGTH
) (
    input  logic                          sys_clk,
    input  logic                          sys_rst,

    input  logic [nmasters-1:0]           m_stb,
    input  logic [nmasters-1:0]           m_we,
    input  logic [nmasters*fml_depth-1:0] m_adr,
    input  logic [nmasters*8-1:0]         m_sel,
    input  logic [nmasters*64-1:0]        m_di,
    output logic [nmasters-1:0]           m_ack,
    output logic [63:0]                   m_do,

    output logic                          s_stb,
    output logic                          s_we,
    output logic [fml_depth-1:0]          s_adr,
    input  logic                          s_ack,
    output logic [7:0]                    s_sel,
    output logic [63:0]                   s_do,
    input  logic [63:0]                   s_di
);

    localparam int              c_OW        = clog2(nmasters);
    localparam int              c_CW        = clog2(burst_length) + 1;
    localparam logic [c_CW-1:0] c_LAST_BEAT = c_CW'(burst_length - 1);

    state_e          state_q;
    logic [c_OW-1:0] owner_q;
    logic [c_OW-1:0] last_q;
    logic [c_CW-1:0] cnt_q;
    logic [c_OW-1:0] w_winner;
    logic            w_any;

    fmlarb_rr #(
        .nmasters (nmasters)
    ) u_rr (
        .req_i    (m_stb),
        .last_i   (last_q),
        .winner_o (w_winner),
        .any_o    (w_any)
    );

    // last resets to nmasters-1 so master 0 wins the first rotation.
    always_ff @(posedge sys_clk) begin
        if (sys_rst) begin
            state_q <= IDLE;
            owner_q <= '0;
            last_q  <= c_OW'(nmasters - 1);
            cnt_q   <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (w_any) begin
                        owner_q <= w_winner;
                        state_q <= ADDR;
                    end
                end
                ADDR: begin
                    // Grant is kept until ack even if the owner drops stb.
                    if (s_ack) begin
                        last_q  <= owner_q;
                        cnt_q   <= '0;
                        state_q <= DATA;
                    end
                end
                DATA: begin
                    cnt_q <= cnt_q + 1'b1;
                    if (cnt_q == c_LAST_BEAT) begin
                        state_q <= IDLE;
                    end
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

    // Slave-side muxes: everything parks at zero outside its own phase so
    // write enables never reach the controller between bursts.
    always_comb begin
        s_stb = 1'b0;
        s_we  = 1'b0;
        s_adr = '0;
        s_sel = '0;
        s_do  = '0;
        m_ack = '0;
        case (state_q)
            ADDR: begin
                s_stb          = m_stb[owner_q];
                s_we           = m_we[owner_q];
                s_adr          = m_adr[int'(owner_q)*fml_depth +: fml_depth];
                m_ack[owner_q] = s_ack;
            end
            DATA: begin
                s_sel = m_sel[int'(owner_q)*8 +: 8];
                s_do  = m_di[int'(owner_q)*64 +: 64];
            end
            default: begin
            end
        endcase
    end

    assign m_do = s_di;

endmodule
`default_nettype wire

// File: tb/tb_fmlarb.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | tb_fmlarb : directed scoreboard bench for the fmlarb FML arbiter         |
// | Rev 1.0                                                                  |
// +--------------------------------------------------------------------------+
module tb_fmlarb;

    localparam int FD = 26;
    localparam int NM = 4;
    localparam int BL = 4;

    logic             sys_clk = 1'b0;
    logic             sys_rst;
    logic [NM-1:0]    m_stb;
    logic [NM-1:0]    m_we;
    logic [NM*FD-1:0] m_adr;
    logic [NM*8-1:0]  m_sel;
    logic [NM*64-1:0] m_di;
    logic [NM-1:0]    m_ack;
    logic [63:0]      m_do;
    logic             s_stb;
    logic             s_we;
    logic [FD-1:0]    s_adr;
    logic             s_ack;
    logic [7:0]       s_sel;
    logic [63:0]      s_do;
    logic [63:0]      s_di;

    fmlarb #(
        .fml_depth    (FD),
        .nmasters     (NM),
        .burst_length (BL)
    ) dut (
        .sys_clk (sys_clk),
        .sys_rst (sys_rst),
        .m_stb   (m_stb),
        .m_we    (m_we),
        .m_adr   (m_adr),
        .m_sel   (m_sel),
        .m_di    (m_di),
        .m_ack   (m_ack),
        .m_do    (m_do),
        .s_stb   (s_stb),
        .s_we    (s_we),
        .s_adr   (s_adr),
        .s_ack   (s_ack),
        .s_sel   (s_sel),
        .s_do    (s_do),
        .s_di    (s_di)
    );

    always #5 sys_clk = ~sys_clk;

    typedef struct {
        int            m;
        logic [FD-1:0] adr;
        logic          we;
        logic [7:0]    sel;
        logic [63:0]   dat;
        logic          drop;
        logic [NM-1:0] raise;
    } exp_t;

    exp_t sb[$];
    int   nchk = 0;
    int   nerr = 0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        nchk++;
        assert (obs === exp) else begin
            nerr++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge sys_clk);
        #1;
    endtask

    task automatic setm(input int i, input logic stb, input logic we,
                        input logic [FD-1:0] adr, input logic [7:0] sel, input logic [63:0] dat);
        m_stb[i]           = stb;
        m_we[i]            = we;
        m_adr[i*FD +: FD]  = adr;
        m_sel[i*8 +: 8]    = sel;
        m_di[i*64 +: 64]   = dat;
    endtask

    task automatic push(input int m, input logic [FD-1:0] adr, input logic we, input logic [7:0] sel,
                        input logic [63:0] dat, input logic drop, input logic [NM-1:0] raise);
        exp_t e;
        e.m = m; e.adr = adr; e.we = we; e.sel = sel; e.dat = dat; e.drop = drop; e.raise = raise;
        sb.push_back(e);
    endtask

    task automatic do_reset();
        sys_rst = 1'b1;
        m_stb   = '0;
        s_ack   = 1'b0;
        step();
        step();
        sys_rst = 1'b0;
    endtask

    // Pops the next expected grant, acks it after ack_delay cycles and
    // walks the data burst. Entered and left at 3 time units past an edge.
    task automatic serve(input int ack_delay);
        exp_t e;
        int   n;
        e = sb.pop_front();
        n = 0;
        while (s_stb !== 1'b1 && n < 40) begin
            step();
            #2;
            n++;
        end
        chk("grant_wait", 64'(n < 40), 64'd1);
        for (int d = 0; d < ack_delay; d++) begin
            chk("addr_hold_stb", 64'(s_stb), 64'd1);
            chk("addr_hold_adr", 64'(s_adr), 64'(e.adr));
            chk("addr_no_ack", 64'(m_ack), 64'd0);
            chk("addr_sel_zero", 64'(s_sel), 64'd0);
            step();
            #2;
        end
        s_ack = 1'b1;
        #1;
        chk("ack_onehot", 64'(m_ack), 64'(1 << e.m));
        chk("ack_adr", 64'(s_adr), 64'(e.adr));
        chk("ack_we", 64'(s_we), 64'(e.we));
        chk("ack_stb", 64'(s_stb), 64'd1);
        step();
        s_ack = 1'b0;
        if (e.drop) m_stb[e.m] = 1'b0;
        for (int b = 0; b < BL; b++) begin
            s_di = {$urandom, $urandom};
            m_di[e.m*64 +: 64] = e.dat + 64'(b);
            if (b == 1) m_stb = m_stb | e.raise;
            #2;
            chk("data_mdo", m_do, s_di);
            chk("data_stb", 64'(s_stb), 64'd0);
            chk("data_sel", 64'(s_sel), 64'(e.sel));
            chk("data_do", s_do, e.dat + 64'(b));
            chk("data_ack", 64'(m_ack), 64'd0);
            step();
        end
        #2;
        chk("idle_stb", 64'(s_stb), 64'd0);
        chk("idle_sel", 64'(s_sel), 64'd0);
        chk("idle_do", s_do, 64'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        sys_rst = 1'b1;
        m_stb = '0; m_we = '0; m_adr = '0; m_sel = '0; m_di = '0;
        s_ack = 1'b0; s_di = 64'h0123_4567_89AB_CDEF;

        // Reset levels
        do_reset();
        #2;
        chk("rst_stb", 64'(s_stb), 64'd0);
        chk("rst_ack", 64'(m_ack), 64'd0);
        chk("rst_sel", 64'(s_sel), 64'd0);
        chk("rst_do", s_do, 64'd0);
        chk("rst_we", 64'(s_we), 64'd0);
        chk("rst_mdo", m_do, 64'h0123_4567_89AB_CDEF);

        // Single read from master 1
        step();
        setm(1, 1'b1, 1'b0, 26'h100, 8'h0F, 64'h1111_0000);
        push(1, 26'h100, 1'b0, 8'h0F, 64'h1111_0000, 1'b1, '0);
        #2;
        chk("single_stb_lat0", 64'(s_stb), 64'd0);
        step();
        #2;
        chk("single_stb_lat1", 64'(s_stb), 64'd1);
        serve(3);

        // Simultaneous requests from reset: rotation 0,1,2,3,0
        do_reset();
        for (int i = 0; i < NM; i++) setm(i, 1'b1, 1'b0, 26'(32'h10 * (i + 1)), 8'(i + 1), 64'(32'h100 * (i + 1)));
        for (int i = 0; i < NM; i++) push(i, 26'(32'h10 * (i + 1)), 1'b0, 8'(i + 1), 64'(32'h100 * (i + 1)), 1'b0, '0);
        push(0, 26'h10, 1'b0, 8'd1, 64'h100, 1'b1, '0);
        #2;
        for (int i = 0; i < NM + 1; i++) serve(0);

        // Write routing: master 2 writes, master 1 drives garbage without stb
        do_reset();
        setm(1, 1'b0, 1'b1, 26'h3FF_FFFF, 8'h5A, 64'hDEAD_BEEF_DEAD_BEEF);
        setm(2, 1'b1, 1'b1, 26'h2A0, 8'hFF, 64'hA000_0000_0000_00A0);
        push(2, 26'h2A0, 1'b1, 8'hFF, 64'hA000_0000_0000_00A0, 1'b1, '0);
        #2;
        chk("wr_idle_sel", 64'(s_sel), 64'd0);
        step();
        #2;
        serve(2);

        // Fairness: master 0 continuous, master 3 joins during its data phase
        do_reset();
        setm(1, 1'b0, 1'b0, 26'h0, 8'h00, 64'h0);
        setm(2, 1'b0, 1'b0, 26'h0, 8'h00, 64'h0);
        setm(3, 1'b0, 1'b0, 26'h333, 8'h33, 64'h3300);
        setm(0, 1'b1, 1'b0, 26'h040, 8'h0C, 64'h0C00);
        push(0, 26'h040, 1'b0, 8'h0C, 64'h0C00, 1'b0, 4'b1000);
        push(3, 26'h333, 1'b0, 8'h33, 64'h3300, 1'b1, '0);
        push(0, 26'h040, 1'b0, 8'h0C, 64'h0C00, 1'b1, '0);
        #2;
        serve(0);
        serve(0);
        serve(0);

        // Late ack with a competing requester, then a stray ack in IDLE
        do_reset();
        setm(0, 1'b1, 1'b0, 26'h0AA, 8'h01, 64'hAA00);
        setm(1, 1'b1, 1'b1, 26'h0BB, 8'hF0, 64'hBB00);
        push(0, 26'h0AA, 1'b0, 8'h01, 64'hAA00, 1'b1, '0);
        push(1, 26'h0BB, 1'b1, 8'hF0, 64'hBB00, 1'b1, '0);
        #2;
        serve(20);
        serve(0);
        s_ack = 1'b1;
        for (int i = 0; i < 3; i++) begin
            step();
            #2;
            chk("stray_ack", 64'(m_ack), 64'd0);
            chk("stray_stb", 64'(s_stb), 64'd0);
        end
        s_ack = 1'b0;

        // Reset during beat 2 of a burst abandons it
        do_reset();
        setm(0, 1'b1, 1'b0, 26'h040, 8'h0C, 64'h0C00);
        setm(1, 1'b0, 1'b0, 26'h111, 8'h11, 64'h1100);
        #2;
        step();
        #2;
        chk("mid_pre_stb", 64'(s_stb), 64'd1);
        s_ack = 1'b1;
        step();
        s_ack = 1'b0;
        step();
        step();
        #2;
        chk("mid_beat2_sel", 64'(s_sel), 64'h0C);
        sys_rst = 1'b1;
        m_stb   = 4'b1010;
        step();
        sys_rst = 1'b0;
        #2;
        chk("mid_rst_stb", 64'(s_stb), 64'd0);
        chk("mid_rst_sel", 64'(s_sel), 64'd0);
        chk("mid_rst_ack", 64'(m_ack), 64'd0);
        step();
        #2;
        chk("mid_regrant_stb", 64'(s_stb), 64'd1);
        chk("mid_regrant_adr", 64'(s_adr), 64'h111);
        push(1, 26'h111, 1'b0, 8'h11, 64'h1100, 1'b1, '0);
        serve(1);

        $display("Simulation finished: %0d checks, %0d errors", nchk, nerr);
        $finish;
    end

endmodule
`default_nettype wire
